// File: rtl/core_pkg.sv
// Shared types for the core load/store unit: funct3 encodings, LSU FSM states
// and exception codes.
package core_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'd0,
      F3_H  = 3'd1,
      F3_W  = 3'd2,
      F3_BU = 3'd4,
      F3_HU = 3'd5
   } funct3_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR,
      ST_RESP,
      ST_EXC
   } lsu_state_e;

   typedef enum logic [1:0] {
      EXC_LD_MISALIGN = 2'd0,
      EXC_ST_MISALIGN = 2'd1,
      EXC_ILLEGAL     = 2'd2
   } exc_code_e;

endpackage

// File: rtl/core_lsu_align.sv
// Combinational request checking, load extraction/extension and store
// byte-enable/data replication for the LSU.
module core_lsu_align
   import core_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic        illegal,
   output logic        misaligned,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      illegal = is_store ? (funct3 > 3'd2)
                         : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);

      case (funct3)
         F3_H, F3_HU: misaligned = addr_lo[0];
         F3_W:        misaligned = (addr_lo != 2'b00);
         default:     misaligned = 1'b0;
      endcase

      shifted = rword >> {addr_lo, 3'b000};
      case (funct3)
         F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
         F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
         default: rdata_ext = shifted;
      endcase

      case (funct3[1:0])
         2'd0: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         2'd1: begin
            byte_en   = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
         end
         default: begin
            byte_en   = 4'b1111;
            wdata_rep = wdata;
         end
      endcase
   end

endmodule

// File: rtl/core_lsu.sv
// RV32I load/store unit: one request at a time, fixed-latency read port,
// single-cycle write port, registered strobes and exception reporting.
module core_lsu
   import core_pkg::*;
#(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clk_en,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic          i_is_store,
   input  logic [2:0]    i_funct3,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic          o_rvalid,
   output logic [DW-1:0] o_rdata,
   output logic          o_exc,
   output logic [1:0]    o_exc_code,
   output logic          o_lsu_read,
   output logic [AW-1:0] o_r_lsu_addr,
   input  logic [DW-1:0] i_r_lsu_data,
   output logic          o_lsu_write,
   output logic [AW-1:0] o_w_lsu_addr,
   output logic [3:0]    o_w_lsu_byte_en,
   output logic [DW-1:0] o_w_lsu_data
);

   localparam logic [2:0] WAIT_LAST = 3'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

   lsu_state_e  state;
   logic [2:0]  cnt;
   logic [2:0]  f3_q;
   logic [1:0]  alo_q;

   logic        idle;
   logic [2:0]  al_f3;
   logic [1:0]  al_lo;
   logic        al_illegal;
   logic        al_misaligned;
   logic [3:0]  al_byte_en;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;

   // The aligner sees the live request while idle and the latched one afterwards.
   assign idle  = (state == ST_IDLE);
   assign al_f3 = idle ? i_funct3 : f3_q;
   assign al_lo = idle ? i_addr[1:0] : alo_q;

   core_lsu_align u_align (
      .is_store   (i_is_store),
      .funct3     (al_f3),
      .addr_lo    (al_lo),
      .rword      (i_r_lsu_data),
      .wdata      (i_wdata),
      .illegal    (al_illegal),
      .misaligned (al_misaligned),
      .byte_en    (al_byte_en),
      .wdata_rep  (al_wdata),
      .rdata_ext  (al_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         f3_q            <= '0;
         alo_q           <= '0;
         o_ready         <= 1'b1;
         o_rvalid        <= 1'b0;
         o_rdata         <= '0;
         o_exc           <= 1'b0;
         o_exc_code      <= EXC_LD_MISALIGN;
         o_lsu_read      <= 1'b0;
         o_r_lsu_addr    <= '0;
         o_lsu_write     <= 1'b0;
         o_w_lsu_addr    <= '0;
         o_w_lsu_byte_en <= '0;
         o_w_lsu_data    <= '0;
      end else if (i_clk_en) begin
         o_lsu_read  <= 1'b0;
         o_lsu_write <= 1'b0;
         o_rvalid    <= 1'b0;
         o_exc       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_valid) begin
                  f3_q    <= i_funct3;
                  alo_q   <= i_addr[1:0];
                  o_ready <= 1'b0;
                  if (al_illegal || al_misaligned) begin
                     state <= ST_EXC;
                     o_exc <= 1'b1;
                     if (al_illegal)
                        o_exc_code <= EXC_ILLEGAL;
                     else if (i_is_store)
                        o_exc_code <= EXC_ST_MISALIGN;
                     else
                        o_exc_code <= EXC_LD_MISALIGN;
                  end else if (i_is_store) begin
                     state           <= ST_WR;
                     o_lsu_write     <= 1'b1;
                     o_w_lsu_addr    <= {i_addr[AW-1:2], 2'b00};
                     o_w_lsu_byte_en <= al_byte_en;
                     o_w_lsu_data    <= al_wdata;
                  end else begin
                     state        <= ST_RD_REQ;
                     o_lsu_read   <= 1'b1;
                     o_r_lsu_addr <= {i_addr[AW-1:2], 2'b00};
                  end
               end
            end
            // With a one-cycle read latency there is nothing left to wait for.
            ST_RD_REQ: begin
               cnt <= '0;
               if (READ_LATENCY == 1) begin
                  o_rdata  <= al_rdata;
                  o_rvalid <= 1'b1;
                  state    <= ST_RESP;
               end else begin
                  state <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (cnt == WAIT_LAST) begin
                  cnt      <= '0;
                  o_rdata  <= al_rdata;
                  o_rvalid <= 1'b1;
                  state    <= ST_RESP;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            ST_RESP, ST_WR, ST_EXC: begin
               state   <= ST_IDLE;
               o_ready <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter READ_LATENCY, default 2, enabled cycles from read request to valid read data; legal range 1..7.
REQ-004 i_clk  in  1  clock; reset i_rst, synchronous, active-high; clock i_clk.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_clk_en  in  1  global clock enable; all state advances only when high.
REQ-007 i_valid  in  1  upstream request valid.
REQ-008 o_ready  out  1  LSU can accept a request.
REQ-009 i_is_store  in  1  1 = store, 0 = load.
REQ-010 i_funct3  in  3  RV32I width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-011 i_addr  in  AW  byte address.
REQ-012 i_wdata  in  DW  store data, LSB-aligned.
REQ-013 o_rvalid  out  1  one-cycle load-complete pulse.
REQ-014 o_rdata  out  DW  extended load result.
REQ-015 o_exc  out  1  one-cycle exception pulse; o_exc_code out 2: 0 misaligned load, 1 misaligned store, 2 illegal funct3.
REQ-016 o_lsu_read, o_r_lsu_addr(AW), i_r_lsu_data(DW): memory read port.
REQ-017 o_lsu_write, o_w_lsu_addr(AW), o_w_lsu_byte_en(4), o_w_lsu_data(DW): memory write port.

Function
REQ-018 Request SHALL be accepted when i_valid & o_ready & i_clk_en; o_ready high only in IDLE.
REQ-019 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR, RESP, EXC.
REQ-020 IDLE on accept SHALL go: EXC if illegal or misaligned; else RD_REQ (load) or WR (store); request fields latched.
REQ-021 Illegal: load funct3 in {3,6,7}; store funct3 > 2.
REQ-022 Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; byte never misaligned; illegal takes precedence.
REQ-023 EXC SHALL assert o_exc with code for one cycle, issue no memory access, return to IDLE.
REQ-024 RD_REQ SHALL assert o_lsu_read for exactly one enabled cycle with o_r_lsu_addr = {addr[AW-1:2],2'b00}, then go RD_WAIT.
REQ-025 RD_WAIT SHALL count READ_LATENCY-1 further enabled cycles (0 if latency 1), then sample i_r_lsu_data and go RESP.
REQ-026 RESP SHALL pulse o_rvalid one cycle with o_rdata = sampled word shifted right by 8*addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged; then IDLE.
REQ-027 WR SHALL assert o_lsu_write one enabled cycle: word-aligned address; byte_en SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; data SB {4{b}}, SH {2{h}}, SW as-is; then IDLE.
REQ-028 o_rdata SHALL hold last load result until next RESP; o_lsu_read/o_lsu_write/o_rvalid/o_exc zero outside their states.
REQ-029 i_clk_en low SHALL freeze state, counter and all outputs.
REQ-030 Throughput: store 2 cycles, load READ_LATENCY+2 cycles, exception 2 cycles, request to next o_ready.

Reset
REQ-031 i_rst SHALL force IDLE, counter 0, o_rdata 0, o_exc_code 0, all strobes 0; o_ready 1 the cycle after.
REQ-032 Reset mid-load SHALL abandon the read; no o_rvalid for it.

Structure
REQ-033 core_pkg SHALL hold funct3 enum, LSU state enum, exception-code enum.
REQ-034 Combinational align/extend/byte-enable logic SHALL be sub-module core_lsu_align.

Verification
REQ-035 LB addr 0x103, memory word 0x80FF_1234 -> one read to 0x100, o_rvalid after 4 cycles, o_rdata 0xFFFF_FF80.
REQ-036 SH addr 0x206, wdata 0x0000_ABCD -> o_w_lsu_addr 0x204, byte_en 4'b1100, data 0xABCD_ABCD, one-cycle strobe.
REQ-037 LW addr 0x102 -> o_exc, code 0, no o_lsu_read; funct3 3 store -> code 2.
REQ-038 i_clk_en low 3 cycles during RD_WAIT -> o_rvalid delayed by exactly 3 cycles, data correct.
REQ-039 i_rst in RD_WAIT -> no o_rvalid, o_ready next cycle, following LHU 0x102 of 0x8001_0000 -> 0x0000_8001.
